intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
- Interrupt/exception controller sequencing the CPU's Cause/EPC/Status path.
- Captures external IRQ edges and synchronous exception pulses (overflow, syscall) and applies Status masking.
- Selects one source by fixed priority and runs an Intr/Inta handshake with the CPU.
- Supplies the formatted Cause word plus a one-cycle Cause write strobe, then blocks further requests until eret.

Parameters:
- NSRC, 8, number of external interrupt lines (1..8); line i maps to Cause.IP[8+i].

Ports:
- Clk  in  1  system clock, rising edge.
- Clrn  in  1  asynchronous active-low reset.
- Irq  in  NSRC  external interrupt lines, level, synchronous to Clk.
- Exc_ov  in  1  one-cycle pulse: ALU overflow on current instruction.
- Exc_sys  in  1  one-cycle pulse: syscall executed.
- Sta_ie  in  1  Status global interrupt enable.
- Sta_im  in  NSRC  Status per-line mask; 1 = enabled.
- Inta  in  1  CPU acknowledge, one cycle, at instruction boundary.
- Eret  in  1  one-cycle pulse: eret executed.
- Intr  out  1  request to CPU (registered).
- Cause  out  32  {16'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b00}; IP bits above NSRC read 0.
- Wcau  out  1  Cause write strobe, one cycle.
- Busy  out  1  handler in service (state SERV).

Behaviour:
- Reset (async, Clrn=0): state IDLE; pending, irq_q, exc flags all 0; Intr=0, Wcau=0, Busy=0, Cause=0.
- Edge capture: irq_q <= Irq each cycle. Rising edge (Irq & ~irq_q) sets pend[i] in any state, even if masked.
  - irq_q resets to 0, so a line already high at reset release yields one pending.
- Exception capture: Exc_ov sets ov_f; Exc_sys sets sys_f. Flags are captured in any state and are unmaskable (ignore Sta_ie/Sta_im).
- Eligibility:
  - req_exc = ov_f | sys_f.
  - req_irq = Sta_ie & |(pend & Sta_im).
  - any = req_exc | req_irq.
- Priority: ov_f > sys_f > lowest-index eligible irq line.
- ExcCode values: 12 = overflow, 8 = syscall, 0 = interrupt.
- State IDLE:
  - If any: next state REQ, Intr=1 from the next cycle.
  - Eret ignored.
- State REQ (Intr=1):
  - Inta=1: grant the current winner.
    - Cause <= {IP = pend snapshot including same-cycle edges, ExcCode}.
    - Clear the winner's pend bit, or its flag.
    - Wcau=1 next cycle, for exactly one cycle.
    - Intr drops next cycle; go to SERV.
  - Inta=0 and any=0 (mask changed, no exception): withdraw Intr next cycle, return to IDLE.
  - Inta and withdrawal in the same cycle: Inta wins, winner computed from the current cycle's inputs.
  - Eret ignored.
- State SERV (Busy=1, Intr=0):
  - New edges and exceptions keep accumulating.
  - Eret: next state IDLE; a pending eligible source re-requests one cycle later (IDLE->REQ).
  - Inta in SERV is ignored.
- Simultaneous clear and set of the same pend bit (new edge on the granted line during Inta): set wins; bit stays 1.
- Exc_ov and Exc_sys together: both flags set; overflow served first, syscall on the next round.
- Cause holds its value between grants; only grants update it.
- Intr latency: source event cycle N -> pend set at edge N+1 -> Intr=1 at N+2.
- Reset mid-handshake: every state/output returns to reset values immediately; pending lost.

Decomposition:
- Shared package intr_pkg:
  - ExcCode constants EXC_INT=5'd0, EXC_SYS=5'd8, EXC_OV=5'd12.
  - State encoding IDLE/REQ/SERV.
  - Cause field positions (IP_LSB=8, EXC_LSB=2).
- One sub-module: intr_prio_enc — combinational fixed-priority encoder.
  - Inputs: ov_f, sys_f, masked pend vector.
  - Outputs: valid, ExcCode, one-hot grant.

Test Plan:
- Reset with Irq=8'h00, then pulse Irq[3] (Sta_ie=1, Sta_im=8'hFF) -> Intr=1 two cycles later; Inta -> Cause=32'h0000_0800, Wcau one cycle, Busy=1, Intr=0.
- Irq[5] and Irq[2] rise the same cycle -> first grant Cause.ExcCode=0, IP=8'h24, pend[2] cleared; after Eret, second Intr, grant clears pend[5], Cause=32'h0000_2000.
- Sta_im=8'h00 with Irq[1] edge -> no Intr; set Sta_im[1]=1 -> Intr asserts; clear Sta_im[1] before Inta -> Intr withdrawn next cycle, pend[1] still set.
- Exc_ov and Exc_sys pulse together with Sta_ie=0 -> Intr asserts; first grant Cause=32'h0000_0030 (ExcCode 12); after Eret, second grant Cause=32'h0000_0020 (ExcCode 8).
- In SERV, Irq[0] edge plus spurious Inta -> no Wcau, Cause unchanged; Eret -> Intr=1 one cycle after IDLE re-entry, grant Cause=32'h0000_0100.
- Drive Clrn=0 during REQ with pending bits set -> Intr, Busy, Wcau, Cause go to 0 immediately; after release with Irq=0, no request.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt/exception controller.
package intr_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int IP_LSB  = 8;
  localparam int EXC_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  // Pack IP bits and exception code into the Cause register layout.
  function automatic logic [31:0] fmt_cause(input logic [7:0] ip, input logic [4:0] code);
    logic [31:0] c;
    c = '0;
    c[IP_LSB +: 8]  = ip;
    c[EXC_LSB +: 5] = code;
    return c;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority selector: overflow, then syscall, then lowest-index line.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            ov_f_i,
  input  logic            sys_f_i,
  input  logic [NSRC-1:0] pend_i,   // already masked by Status
  output logic            valid_o,
  output logic [4:0]      code_o,
  output logic [NSRC-1:0] gnt_o     // one-hot line grant, zero when an exception wins
);

  // Exceptions pre-empt lines; the downward scan leaves the lowest set bit.
  always_comb begin
    valid_o = ov_f_i | sys_f_i | (|pend_i);
    code_o  = EXC_INT;
    gnt_o   = '0;
    if (ov_f_i) begin
      code_o = EXC_OV;
    end else if (sys_f_i) begin
      code_o = EXC_SYS;
    end else begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (pend_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt/exception controller: edge capture, masking, priority and Intr/Inta handshake.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic [NSRC-1:0] Irq,
  input  logic            Exc_ov,
  input  logic            Exc_sys,
  input  logic            Sta_ie,
  input  logic [NSRC-1:0] Sta_im,
  input  logic            Inta,
  input  logic            Eret,
  output logic            Intr,
  output logic [31:0]     Cause,
  output logic            Wcau,
  output logic            Busy
);

  state_e          state_q, state_d;
  logic [NSRC-1:0] irq_q, pend_q, pend_d;
  logic            ov_q, ov_d, sys_q, sys_d;
  logic            intr_q, busy_q, wcau_q;
  logic [31:0]     cause_q, cause_d;

  logic [NSRC-1:0] rise, masked, gnt, clr_pend;
  logic            valid, grant;
  logic [4:0]      code;
  logic [7:0]      ip;

  assign rise   = Irq & ~irq_q;
  assign masked = Sta_ie ? (pend_q & Sta_im) : '0;

  intr_prio_enc #(.NSRC(NSRC)) u_enc (
    .ov_f_i  (ov_q),
    .sys_f_i (sys_q),
    .pend_i  (masked),
    .valid_o (valid),
    .code_o  (code),
    .gnt_o   (gnt)
  );

  // Acknowledge always wins in REQ; a grant with no winner still enters service.
  assign grant    = (state_q == REQ) && Inta;
  assign clr_pend = grant ? gnt : '0;

  // Pending/flag update: clears from the grant, sets from new events; set wins.
  always_comb begin
    pend_d = (pend_q & ~clr_pend) | rise;
    ov_d   = (ov_q  & ~(grant && code == EXC_OV))  | Exc_ov;
    sys_d  = (sys_q & ~(grant && code == EXC_SYS)) | Exc_sys;
    ip     = '0;
    ip[NSRC-1:0] = pend_q | rise;
    cause_d = grant ? fmt_cause(ip, code) : cause_q;
  end

  // Handshake sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = REQ;
      REQ:     if (Inta) state_d = SERV;
               else if (!valid) state_d = IDLE;
      SERV:    if (Eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and registered outputs.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      ov_q    <= 1'b0;
      sys_q   <= 1'b0;
      intr_q  <= 1'b0;
      busy_q  <= 1'b0;
      wcau_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= Irq;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      sys_q   <= sys_d;
      intr_q  <= (state_d == REQ);
      busy_q  <= (state_d == SERV);
      wcau_q  <= grant;
      cause_q <= cause_d;
    end
  end

  assign Intr  = intr_q;
  assign Busy  = busy_q;
  assign Wcau  = wcau_q;
  assign Cause = cause_q;

endmodule
